// File: rtl/vga_pkg.sv
// Shared constants, FSM state encoding and pixel/address types
// for the frame RAM arbiter and other VGA_Sync users.
package vga_pkg;

    localparam int FB_ADDR_W = 15;
    localparam int PIX_W     = 8;
    localparam int FB_COLS   = 160;
    localparam int H_VIS_ORG = 144;
    localparam int V_VIS_ORG = 34;
    localparam int BURST_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        DISP,
        WR0,
        WR1
    } arb_state_t;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [PIX_W-1:0]     pixel_t;

endpackage

// File: rtl/vga_fb_addr.sv
// Maps the VGA scan position to a frame buffer read address:
// 4x4 upscale, addr = row*FB_W + col, truncated to ADDR_W.
module vga_fb_addr
    import vga_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int FB_W   = FB_COLS,
    parameter int H_ORG  = H_VIS_ORG,
    parameter int V_ORG  = V_VIS_ORG
) (
    input  logic [9:0]        pos_H,
    input  logic [9:0]        pos_V,
    output logic [ADDR_W-1:0] rd_addr
);

    logic [9:0]        dh;
    logic [9:0]        dv;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;

    assign dh  = pos_H - 10'(H_ORG);
    assign dv  = pos_V - 10'(V_ORG);
    assign col = ADDR_W'(dh >> 2);
    assign row = ADDR_W'(dv >> 2);

    // 160 = 128 + 32, so the row product is two shifts and an add
    generate
        if (FB_W == 160) begin : g_shift
            assign rd_addr = (row << 7) + (row << 5) + col;
        end else begin : g_mul
            assign rd_addr = row * ADDR_W'(FB_W) + col;
        end
    endgenerate

endmodule

// File: rtl/vga_frame_arbiter.sv
// Single-port frame RAM arbiter: scanout owns the port while
// vga_Ready, two writers share blanking round-robin in bursts.
module vga_frame_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W    = FB_ADDR_W,
    parameter int DATA_W    = PIX_W,
    parameter int FB_W      = FB_COLS,
    parameter int H_ORG     = H_VIS_ORG,
    parameter int V_ORG     = V_VIS_ORG,
    parameter int MAX_BURST = BURST_MAX
) (
    input  logic              vga_CLK,
    input  logic              vga_RST_n,
    input  logic [9:0]        pos_H,
    input  logic [9:0]        pos_V,
    input  logic              vga_Ready,
    input  logic [1:0]        wr_req,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    output logic [1:0]        wr_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              frame_start
);

    localparam int CW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 2);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              last_owner;
    logic              last_nxt;
    logic [CW-1:0]     burst_cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              beat;
    logic              sel;
    logic              vis_d;
    logic [ADDR_W-1:0] rd_addr;

    vga_fb_addr #(
        .ADDR_W (ADDR_W),
        .FB_W   (FB_W),
        .H_ORG  (H_ORG),
        .V_ORG  (V_ORG)
    ) u_fb_addr (
        .pos_H   (pos_H),
        .pos_V   (pos_V),
        .rd_addr (rd_addr)
    );

    // Arbitration state, round-robin pointer and burst counter
    always_ff @(posedge vga_CLK or negedge vga_RST_n) begin
        if (!vga_RST_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_nxt;
            burst_cnt  <= cnt_nxt;
        end
    end

    // Next state and port mux; scanout always wins when visible.
    // A blank cycle in DISP arbitrates like IDLE so a preempted
    // writer resumes on the first blank cycle.
    always_comb begin
        state_nxt = state;
        last_nxt  = last_owner;
        cnt_nxt   = burst_cnt;
        beat      = 1'b0;
        sel       = 1'b0;
        wr_gnt    = 2'b00;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (vga_RST_n) begin
            if (vga_Ready) begin
                mem_addr  = rd_addr;
                state_nxt = DISP;
                if (state == WR0 || state == WR1) begin
                    last_nxt = (state == WR1);
                end
            end else begin
                unique case (state)
                    IDLE, DISP: begin
                        state_nxt = IDLE;
                        if (|wr_req) begin
                            sel = wr_req[~last_owner] ?
                                  ~last_owner : last_owner;
                            beat      = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = sel ? WR1 : WR0;
                        end
                    end
                    WR0, WR1: begin
                        sel = (state == WR1);
                        if (wr_req[sel]) begin
                            beat    = 1'b1;
                            cnt_nxt = burst_cnt + CW'(1);
                            if (burst_cnt == LAST_CNT) begin
                                state_nxt = IDLE;
                                last_nxt  = sel;
                            end
                        end else begin
                            state_nxt = IDLE;
                            last_nxt  = sel;
                        end
                    end
                endcase
            end
            if (beat) begin
                wr_gnt    = sel ? 2'b10 : 2'b01;
                mem_we    = 1'b1;
                mem_addr  = sel ? wr_addr1 : wr_addr0;
                mem_wdata = sel ? wr_data1 : wr_data0;
            end
        end
    end

    // Pixel pipeline: RAM read latency plus one output register
    always_ff @(posedge vga_CLK or negedge vga_RST_n) begin
        if (!vga_RST_n) begin
            vis_d    <= 1'b0;
            pix_data <= '0;
        end else begin
            vis_d    <= vga_Ready;
            pix_data <= vis_d ? mem_rdata : '0;
        end
    end

    // One-cycle pulse at the scan origin, independent of arbitration
    always_ff @(posedge vga_CLK or negedge vga_RST_n) begin
        if (!vga_RST_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= (pos_H == 10'd0) && (pos_V == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_frame_arbiter.sv
// Bench for vga_frame_arbiter: directed literal checks plus a
// randomized run against a behavioural arbitration model.
module tb_vga_frame_arbiter;

    logic        vga_CLK = 1'b0;
    logic        vga_RST_n = 1'b0;
    logic [9:0]  pos_H = 10'd10;
    logic [9:0]  pos_V = 10'd10;
    logic        vga_Ready = 1'b0;
    logic [1:0]  wr_req = 2'b00;
    logic [14:0] wr_addr0 = '0;
    logic [14:0] wr_addr1 = '0;
    logic [7:0]  wr_data0 = '0;
    logic [7:0]  wr_data1 = '0;
    logic [1:0]  wr_gnt;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  pix_data;
    logic        frame_start;

    int total = 0;
    int bad = 0;

    vga_frame_arbiter dut (
        .vga_CLK     (vga_CLK),
        .vga_RST_n   (vga_RST_n),
        .pos_H       (pos_H),
        .pos_V       (pos_V),
        .vga_Ready   (vga_Ready),
        .wr_req      (wr_req),
        .wr_addr0    (wr_addr0),
        .wr_addr1    (wr_addr1),
        .wr_data0    (wr_data0),
        .wr_data1    (wr_data1),
        .wr_gnt      (wr_gnt),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .pix_data    (pix_data),
        .frame_start (frame_start)
    );

    always #20 vga_CLK = ~vga_CLK;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h",
                     nm, $time, act, exp);
        end
    endtask

    // Frame RAM: unwritten words hold a fixed pattern, word 0 = A5
    logic [7:0] ram   [0:32767];
    bit         wrote [0:32767];

    function automatic logic [7:0] pat(input int a);
        return (a == 0) ? 8'hA5 : 8'((a * 37) ^ (a >> 7));
    endfunction

    function automatic logic [7:0] rd(input int a);
        return wrote[a] ? ram[a] : pat(a);
    endfunction

    always @(posedge vga_CLK) begin
        mem_rdata <= rd(int'(mem_addr));
        if (mem_we) begin
            ram[mem_addr]   <= mem_wdata;
            wrote[mem_addr] <= 1'b1;
        end
    end

    // Behavioural model: owner/beat count, pixel delay line
    int         owner = -1;
    int         last = 1;
    int         beats = 0;
    logic [7:0] q0 = '0;
    logic [7:0] q1 = '0;
    bit         prevfs = 1'b0;

    always @(negedge vga_CLK) begin : model
        int          n;
        logic [1:0]  eg;
        logic        ew;
        int          ea;
        logic [7:0]  ed;
        logic [7:0]  ep;
        bit          ef;
        eg = 2'b00;
        ew = 1'b0;
        ea = 0;
        ed = '0;
        ep = '0;
        ef = 1'b0;
        n = 0;
        if (!vga_RST_n) begin
            owner = -1;
            last = 1;
            beats = 0;
            q0 = '0;
            q1 = '0;
            prevfs = 1'b0;
        end else begin
            if (vga_Ready) begin
                ea = (((int'(pos_V) - 34) / 4) * 160
                      + (int'(pos_H) - 144) / 4) % 32768;
                if (owner >= 0) begin
                    last = owner;
                    owner = -1;
                end
            end else if (owner >= 0) begin
                if (wr_req[owner]) begin
                    n = owner;
                    ew = 1'b1;
                    beats++;
                    if (beats == 8) begin
                        last = owner;
                        owner = -1;
                    end
                end else begin
                    last = owner;
                    owner = -1;
                end
            end else if (wr_req != 2'b00) begin
                n = wr_req[1 - last] ? 1 - last : last;
                ew = 1'b1;
                owner = n;
                beats = 1;
            end
            if (ew) begin
                eg = (n == 1) ? 2'b10 : 2'b01;
                ea = (n == 1) ? int'(wr_addr1) : int'(wr_addr0);
                ed = (n == 1) ? wr_data1 : wr_data0;
            end
            ep = q1;
            q1 = q0;
            q0 = vga_Ready ? rd(ea) : 8'h00;
            ef = prevfs;
            prevfs = (pos_H == 10'd0) && (pos_V == 10'd0);
        end
        chk("m_gnt", int'(wr_gnt), int'(eg));
        chk("m_we", int'(mem_we), int'(ew));
        if (ew || vga_Ready || !vga_RST_n)
            chk("m_addr", int'(mem_addr), ea);
        if (ew)
            chk("m_wdata", int'(mem_wdata), int'(ed));
        chk("m_pix", int'(pix_data), int'(ep));
        chk("m_fs", int'(frame_start), int'(ef));
        chk("inv_we_vis", int'(mem_we && vga_Ready), 0);
        chk("inv_gnt_both", int'(wr_gnt == 2'b11), 0);
    end

    task automatic nxt();
        @(posedge vga_CLK);
        #1;
    endtask

    task automatic setrdy();
        vga_Ready = (pos_H >= 10'd144) && (pos_H < 10'd784) &&
                    (pos_V >= 10'd34) && (pos_V < 10'd514);
    endtask

    task automatic adv();
        if (pos_H == 10'd799) begin
            pos_H = 10'd0;
            pos_V = (pos_V == 10'd524) ? 10'd0 : pos_V + 10'd1;
        end else begin
            pos_H = pos_H + 10'd1;
        end
        setrdy();
    endtask

    // Writers hold request/address/data until granted
    task automatic wdrive(input logic [1:0] g);
        if (wr_req[0] && g[0]) begin
            if ($urandom_range(9) < 7) begin
                wr_addr0 = 15'($urandom);
                wr_data0 = 8'($urandom);
            end else begin
                wr_req[0] = 1'b0;
            end
        end else if (!wr_req[0] && $urandom_range(3) == 0) begin
            wr_req[0] = 1'b1;
            wr_addr0 = 15'($urandom);
            wr_data0 = 8'($urandom);
        end
        if (wr_req[1] && g[1]) begin
            if ($urandom_range(9) < 7) begin
                wr_addr1 = 15'($urandom);
                wr_data1 = 8'($urandom);
            end else begin
                wr_req[1] = 1'b0;
            end
        end else if (!wr_req[1] && $urandom_range(3) == 0) begin
            wr_req[1] = 1'b1;
            wr_addr1 = 15'($urandom);
            wr_data1 = 8'($urandom);
        end
    endtask

    initial begin : main
        int c;
        logic [1:0] g;
        wr_addr0 = 15'h1234;
        wr_data0 = 8'h3C;
        wr_addr1 = 15'h2345;
        wr_data1 = 8'hC3;
        wr_req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge vga_CLK);
            chk("rst_gnt", int'(wr_gnt), 0);
            chk("rst_we", int'(mem_we), 0);
            chk("rst_addr", int'(mem_addr), 0);
            chk("rst_pix", int'(pix_data), 0);
            chk("rst_fs", int'(frame_start), 0);
            nxt();
        end
        vga_RST_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge vga_CLK);
            chk("rr_gnt", int'(wr_gnt), (i < 8 || i == 16) ? 1 : 2);
            chk("rr_we", int'(mem_we), 1);
            chk("rr_addr", int'(mem_addr),
                (i < 8 || i == 16) ? 'h1234 : 'h2345);
            nxt();
        end

        wr_req = 2'b10;
        c = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge vga_CLK);
            if (wr_gnt[1]) c++;
            nxt();
            if (c == 3) wr_req = 2'b00;
        end
        chk("short_cnt", c, 3);

        wr_req = 2'b01;
        @(negedge vga_CLK);
        chk("idle_gnt", int'(wr_gnt), 1);
        nxt();
        @(negedge vga_CLK);
        chk("pre_beat", int'(wr_gnt), 1);
        nxt();
        pos_H = 10'd144;
        pos_V = 10'd34;
        vga_Ready = 1'b1;
        @(negedge vga_CLK);
        chk("pre_gnt", int'(wr_gnt), 0);
        chk("pre_we", int'(mem_we), 0);
        nxt();
        pos_H = 10'd10;
        pos_V = 10'd10;
        vga_Ready = 1'b0;
        @(negedge vga_CLK);
        chk("resume_gnt", int'(wr_gnt), 1);
        chk("resume_addr", int'(mem_addr), 'h1234);
        nxt();
        wr_req = 2'b00;
        nxt();
        nxt();

        pos_H = 10'd144;
        pos_V = 10'd34;
        vga_Ready = 1'b1;
        @(negedge vga_CLK);
        chk("sc_a0", int'(mem_addr), 0);
        nxt();
        pos_H = 10'd148;
        @(negedge vga_CLK);
        chk("sc_a1", int'(mem_addr), 1);
        nxt();
        pos_H = 10'd144;
        pos_V = 10'd38;
        @(negedge vga_CLK);
        chk("sc_a160", int'(mem_addr), 160);
        chk("sc_pix", int'(pix_data), 'hA5);
        nxt();
        pos_H = 10'd10;
        vga_Ready = 1'b0;
        nxt();
        nxt();
        @(negedge vga_CLK);
        chk("blank_pix", int'(pix_data), 0);
        nxt();

        pos_V = 10'd30;
        pos_H = 10'd0;
        setrdy();
        for (int i = 0; i < 9600; i++) begin
            @(negedge vga_CLK);
            g = wr_gnt;
            nxt();
            wdrive(g);
            adv();
        end

        pos_V = 10'd524;
        pos_H = 10'd0;
        setrdy();
        c = 0;
        for (int i = 0; i < 1600; i++) begin
            @(negedge vga_CLK);
            g = wr_gnt;
            if (frame_start) c++;
            nxt();
            wdrive(g);
            adv();
        end
        chk("fs_count", c, 1);

        @(negedge vga_CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
